mouse_dir_tracker: RTL and testbench

- Converts the binned cursor position stream from the PS/2 mouse front end into a full 9-way one-hot motion direction (3x3 compass grid, centre = no motion).
- Successor to the 2-way moving/not-moving indicator, with:
  - parametrised coordinate width
  - a dead-zone
  - sub-threshold drift accumulation
  - an idle timeout back to centre
- Runs entirely in the system clock domain. Sits between the PS/2 decoder and the drawing/control logic.

---
 rtl/mouse_dir_pkg.sv | 37 +++
 rtl/mouse_axis_classify.sv | 27 ++
 rtl/mouse_dir_tracker.sv | 101 ++++++++++
 tb/tb_mouse_dir_tracker.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mouse_dir_pkg.sv
// Shared types and direction encodings for the mouse direction tracker.
// Direction index = row*3 + col, rows/cols ordered up/none/down and left/none/right.
package mouse_dir_pkg;

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_IDLE = 2'd1,
      S_MOVE = 2'd2
   } state_t;

   localparam int DIR_UL = 0;
   localparam int DIR_U  = 1;
   localparam int DIR_UR = 2;
   localparam int DIR_L  = 3;
   localparam int DIR_C  = 4;
   localparam int DIR_R  = 5;
   localparam int DIR_DL = 6;
   localparam int DIR_D  = 7;
   localparam int DIR_DR = 8;

   localparam logic [8:0] DIR_CENTER = 9'b0_0001_0000;

   // Axis codes double as row/column indices, so code == 1 + signed motion.
   localparam logic [1:0] CODE_NEG  = 2'd0;
   localparam logic [1:0] CODE_ZERO = 2'd1;
   localparam logic [1:0] CODE_POS  = 2'd2;

   function automatic logic [8:0] dir_onehot(input logic [1:0] row, input logic [1:0] col);
      logic [8:0] r;
      int         idx;
      r   = '0;
      idx = int'(row) * 3 + int'(col);
      if (idx < 9) r[idx] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/mouse_axis_classify.sv
// Per-axis motion classifier: signed displacement against the anchor,
// compared to a symmetric dead-zone. Purely combinational.
module mouse_axis_classify
   import mouse_dir_pkg::*;
#(
   parameter int COORD_W  = 11,
   parameter int DEADZONE = 2
) (
   input  logic [COORD_W-1:0] pos,
   input  logic [COORD_W-1:0] anchor,
   output logic [1:0]         code
);

   localparam logic signed [COORD_W:0] DZ_POS = (COORD_W+1)'(DEADZONE);
   localparam logic signed [COORD_W:0] DZ_NEG = -DZ_POS;

   // One extra bit keeps the full 0..max span representable without wrap.
   logic signed [COORD_W:0] delta;

   always_comb begin
      delta = $signed({1'b0, pos}) - $signed({1'b0, anchor});
      code  = CODE_ZERO;
      if (delta > DZ_POS)      code = CODE_POS;
      else if (delta < DZ_NEG) code = CODE_NEG;
   end

endmodule

// File: rtl/mouse_dir_tracker.sv
// Turns binned cursor samples into a one-hot 3x3 motion direction with
// dead-zone, drift accumulation against a held anchor, and idle timeout.
module mouse_dir_tracker
   import mouse_dir_pkg::*;
#(
   parameter int COORD_W      = 11,
   parameter int DEADZONE     = 2,
   parameter int IDLE_SAMPLES = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               sample_valid,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [8:0]         ms_dir,
   output logic               dir_valid,
   output logic               moving
);

   localparam int CNT_W = $clog2(IDLE_SAMPLES + 1);
   localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(IDLE_SAMPLES);

   // Handshake: sample_valid is a one-cycle strobe with no back-pressure;
   // dir_valid is a one-cycle pulse, issued only when ms_dir takes a new value.
   state_t             state;
   logic [COORD_W-1:0] anchor_x;
   logic [COORD_W-1:0] anchor_y;
   logic [CNT_W-1:0]   idle_cnt;

   logic [1:0]         code_x;
   logic [1:0]         code_y;
   logic               motion;
   logic [8:0]         new_dir;
   logic [CNT_W-1:0]   idle_nxt;

   mouse_axis_classify #(.COORD_W(COORD_W), .DEADZONE(DEADZONE)) u_cls_x (
      .pos    (x),
      .anchor (anchor_x),
      .code   (code_x)
   );

   mouse_axis_classify #(.COORD_W(COORD_W), .DEADZONE(DEADZONE)) u_cls_y (
      .pos    (y),
      .anchor (anchor_y),
      .code   (code_y)
   );

   always_comb begin
      motion   = (code_x != CODE_ZERO) || (code_y != CODE_ZERO);
      new_dir  = dir_onehot(code_y, code_x);
      idle_nxt = idle_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_INIT;
         ms_dir    <= DIR_CENTER;
         dir_valid <= 1'b0;
         moving    <= 1'b0;
         anchor_x  <= '0;
         anchor_y  <= '0;
         idle_cnt  <= '0;
      end else if (clear) begin
         state     <= S_INIT;
         ms_dir    <= DIR_CENTER;
         dir_valid <= 1'b0;
         moving    <= 1'b0;
         idle_cnt  <= '0;
      end else if (sample_valid) begin
         dir_valid <= 1'b0;
         if (state == S_INIT) begin
            anchor_x <= x;
            anchor_y <= y;
            state    <= S_IDLE;
         end else if (motion) begin
            ms_dir    <= new_dir;
            dir_valid <= (new_dir != ms_dir);
            anchor_x  <= x;
            anchor_y  <= y;
            idle_cnt  <= '0;
            state     <= S_MOVE;
            moving    <= 1'b1;
         end else if (state == S_MOVE) begin
            // Anchor stays put so sub-threshold drift keeps accumulating.
            if (idle_nxt == IDLE_LIMIT) begin
               ms_dir    <= DIR_CENTER;
               dir_valid <= 1'b1;
               moving    <= 1'b0;
               idle_cnt  <= '0;
               state     <= S_IDLE;
            end else begin
               idle_cnt <= idle_nxt;
            end
         end
      end else begin
         dir_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mouse_dir_tracker.sv
// Directed bench for mouse_dir_tracker: default instance plus an
// IDLE_SAMPLES=1 instance, checked through an expected-value queue.
module tb_mouse_dir_tracker;

   localparam int W = 11;

   logic         clk;
   logic         reset;
   logic         clear;
   logic         sv0;
   logic         sv1;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic [8:0]   ms_dir0, ms_dir1;
   logic         dv0, dv1, mv0, mv1;

   logic [10:0]  exp_q[$];
   int           errors = 0;
   int           checks = 0;

   mouse_dir_tracker #(.COORD_W(W), .DEADZONE(2), .IDLE_SAMPLES(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .sample_valid (sv0),
      .x            (x),
      .y            (y),
      .ms_dir       (ms_dir0),
      .dir_valid    (dv0),
      .moving       (mv0)
   );

   mouse_dir_tracker #(.COORD_W(W), .DEADZONE(2), .IDLE_SAMPLES(1)) dut1 (
      .clk          (clk),
      .reset        (reset),
      .clear        (1'b0),
      .sample_valid (sv1),
      .x            (x),
      .y            (y),
      .ms_dir       (ms_dir1),
      .dir_valid    (dv1),
      .moving       (mv1)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [8:0] C  = 9'h010;
   localparam logic [8:0] R  = 9'h020;
   localparam logic [8:0] UL = 9'h001;
   localparam logic [8:0] U  = 9'h002;
   localparam logic [8:0] UR = 9'h004;
   localparam logic [8:0] L  = 9'h008;
   localparam logic [8:0] D  = 9'h080;
   localparam logic [8:0] DR = 9'h100;

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver: one clock of stimulus, expectation queued, outputs checked after the edge
   task automatic step(input int which, input logic r, input logic c, input logic v,
                       input int px, input int py,
                       input logic [8:0] e_dir, input logic e_dv, input logic e_mv,
                       input string tag);
      logic [10:0] e;
      @(negedge clk);
      reset = r;
      clear = c;
      if (which == 0) sv0 = v; else sv1 = v;
      x = W'(px);
      y = W'(py);
      exp_q.push_back({e_dir, e_dv, e_mv});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (which == 0) begin
         check({tag, ".ms_dir"},    ms_dir0,       e[10:2]);
         check({tag, ".dir_valid"}, {8'b0, dv0},   {8'b0, e[1]});
         check({tag, ".moving"},    {8'b0, mv0},   {8'b0, e[0]});
      end else begin
         check({tag, ".ms_dir"},    ms_dir1,       e[10:2]);
         check({tag, ".dir_valid"}, {8'b0, dv1},   {8'b0, e[1]});
         check({tag, ".moving"},    {8'b0, mv1},   {8'b0, e[0]});
      end
      sv0   = 1'b0;
      sv1   = 1'b0;
      clear = 1'b0;
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; sv0 = 1'b0; sv1 = 1'b0; x = '0; y = '0;

      step(0, 1, 0, 1, 500, 0, C, 0, 0, "rst0");
      step(0, 1, 0, 1, 500, 0, C, 0, 0, "rst1");
      check("rst_dut1.ms_dir", ms_dir1, C);
      check("rst_dut1.moving", {8'b0, mv1}, 9'h0);

      step(0, 0, 0, 1, 100, 100, C, 0, 0, "anchor");
      step(0, 0, 0, 1, 110, 100, R, 1, 1, "right");
      step(0, 0, 0, 1, 120, 100, R, 0, 1, "right_again");
      step(0, 0, 0, 1, 118,  98, R, 0, 1, "deadzone");
      step(0, 0, 0, 1, 110,  90, UL, 1, 1, "upleft");
      step(0, 0, 0, 0,   0,   0, UL, 0, 1, "no_sample");

      for (int i = 1; i <= 7; i++)
         step(0, 0, 0, 1, 110, 90, UL, 0, 1, $sformatf("idle%0d", i));
      step(0, 0, 0, 1, 110, 90, C, 1, 0, "idle8");

      step(0, 0, 0, 1, 111, 90, C, 0, 0, "accum1");
      step(0, 0, 0, 1, 112, 90, C, 0, 0, "accum2");
      step(0, 0, 0, 1, 113, 90, R, 1, 1, "accum3");
      step(0, 0, 0, 1, 113, 100, D, 1, 1, "down");

      step(0, 0, 1, 1, 0, 0, C, 0, 0, "clear");
      step(0, 0, 0, 1, 0, 0, C, 0, 0, "post_clear_anchor");
      step(0, 0, 0, 1, 2047, 0, R, 1, 1, "max_x");
      step(0, 0, 0, 1, 2047, 2047, D, 1, 1, "max_y");
      step(0, 0, 0, 1, 0, 0, UL, 1, 1, "max_to_zero");
      step(0, 0, 0, 1, 5, 5, DR, 1, 1, "downright");
      step(0, 0, 0, 1, 10, 0, UR, 1, 1, "upright");
      step(0, 0, 0, 1, 0, 0, L, 1, 1, "left");
      step(0, 0, 0, 1, 0, 10, D, 1, 1, "down2");
      step(0, 0, 0, 1, 0, 0, U, 1, 1, "up");

      step(1, 0, 0, 1, 100, 100, C, 0, 0, "i1_anchor");
      step(1, 0, 0, 1, 110, 100, R, 1, 1, "i1_right");
      step(1, 0, 0, 1, 110, 100, C, 1, 0, "i1_timeout");
      step(1, 0, 0, 0, 110, 100, C, 0, 0, "i1_hold");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
